// File: rtl/sdram_inport_arbiter.sv
// sdram_inport_arbiter: round-robin sharing of the single SDRAM controller inport
// between NUM_REQ requesters. Accepted transactions are tracked in an in-order
// ID FIFO so that core ack/error/read data return to the originating requester.
// Optional feature macro: SDRAM_ARB_PRIO0_EN (requester 0 gets fixed top priority).
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_ARB   | choose next pending requester (blocked while ID FIFO full)
// ST_GRANT | core sees the live fields of gnt_idx_q until accept/withdraw
`timescale 1ns/1ps

module sdram_inport_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int OUTST_DEPTH = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [4*NUM_REQ-1:0]            req_wr_i,
  input  logic [NUM_REQ-1:0]              req_rd_i,
  input  logic [32*NUM_REQ-1:0]           req_addr_i,
  input  logic [32*NUM_REQ-1:0]           req_wdata_i,
  output logic [NUM_REQ-1:0]              req_accept_o,
  output logic [NUM_REQ-1:0]              req_ack_o,
  output logic [NUM_REQ-1:0]              req_error_o,
  output logic [31:0]                     req_rdata_o,
  output logic [3:0]                      inport_wr_o,
  output logic                            inport_rd_o,
  output logic [31:0]                     inport_addr_o,
  output logic [31:0]                     inport_wdata_o,
  input  logic                            inport_accept_i,
  input  logic                            inport_ack_i,
  input  logic                            inport_error_i,
  input  logic [31:0]                     inport_rdata_i,
  output logic [$clog2(OUTST_DEPTH):0]    outst_cnt_o,
  output logic                            proto_err_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int PW = $clog2(OUTST_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {ST_ARB, ST_GRANT} state_e;

  state_e          state_q;
  logic [IW-1:0]   gnt_idx_q;
  logic [IW-1:0]   rr_ptr_q;
  logic [IW-1:0]   fifo_q [OUTST_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic            proto_err_q;

  logic [NUM_REQ-1:0] pend;
  logic [IW-1:0]      sel_idx;
  logic               sel_vld;
  logic [IW:0]        cand;
  logic [IW-1:0]      rr_nxt;
  logic [IW-1:0]      head;
  logic               full, empty, push, pop, gnt_pend;

  assign full     = (cnt_q == CW'(OUTST_DEPTH));
  assign empty    = (cnt_q == '0);
  assign push     = (state_q == ST_GRANT) && inport_accept_i;
  assign pop      = inport_ack_i && !empty;
  assign head     = fifo_q[rd_ptr_q];
  assign gnt_pend = pend[gnt_idx_q];
  assign rr_nxt   = (gnt_idx_q == IW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;

  // Pending flags: any write byte lane or a read.
  always_comb begin
    pend = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      pend[r] = (|req_wr_i[4*r +: 4]) | req_rd_i[r];
    end
  end

  // Round-robin pick starting at rr_ptr_q; requester 0 may override.
  always_comb begin
    sel_idx = '0;
    sel_vld = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!sel_vld && pend[cand[IW-1:0]]) begin
        sel_idx = cand[IW-1:0];
        sel_vld = 1'b1;
      end
    end
`ifdef SDRAM_ARB_PRIO0_EN
    if (pend[0]) begin
      sel_idx = '0;
      sel_vld = 1'b1;
    end
`endif
  end

  // Arbitration FSM: one grant at a time, held until accepted or withdrawn.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_ARB;
      gnt_idx_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      case (state_q)
        ST_ARB: begin
          if (!full && sel_vld) begin
            gnt_idx_q <= sel_idx;
            state_q   <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (inport_accept_i) begin
            state_q <= ST_ARB;
`ifdef SDRAM_ARB_PRIO0_EN
            // Requester 0 grants leave the rotation among 1..NUM_REQ-1 untouched.
            if (gnt_idx_q != '0) rr_ptr_q <= rr_nxt;
`else
            rr_ptr_q <= rr_nxt;
`endif
          end else if (!gnt_pend) begin
            state_q <= ST_ARB;
          end
        end
        default: state_q <= ST_ARB;
      endcase
    end
  end

  // ID FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= gnt_idx_q;
  end

  // ID FIFO pointers, occupancy and sticky protocol error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (inport_ack_i && empty) proto_err_q <= 1'b1;
    end
  end

  // Core-side mux plus per-requester accept/ack/error steering.
  always_comb begin
    inport_wr_o    = '0;
    inport_rd_o    = 1'b0;
    inport_addr_o  = '0;
    inport_wdata_o = '0;
    req_accept_o   = '0;
    req_ack_o      = '0;
    req_error_o    = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (state_q == ST_GRANT && gnt_idx_q == IW'(r)) begin
        inport_wr_o    = req_wr_i[4*r +: 4];
        inport_rd_o    = req_rd_i[r];
        inport_addr_o  = req_addr_i[32*r +: 32];
        inport_wdata_o = req_wdata_i[32*r +: 32];
      end
      req_accept_o[r] = push && (gnt_idx_q == IW'(r));
      req_ack_o[r]    = pop && (head == IW'(r));
      req_error_o[r]  = pop && (head == IW'(r)) && inport_error_i;
    end
  end

  assign req_rdata_o = inport_rdata_i;
  assign outst_cnt_o = cnt_q;
  assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_sdram_inport_arbiter.sv
// Directed bench for sdram_inport_arbiter (NUM_REQ=4, OUTST_DEPTH=4).
`timescale 1ns/1ps

module tb_sdram_inport_arbiter;
  localparam int N = 4;
  localparam int D = 4;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic [4*N-1:0]   req_wr;
  logic [N-1:0]     req_rd;
  logic [32*N-1:0]  req_addr, req_wdata;
  logic [N-1:0]     req_accept, req_ack, req_error;
  logic [31:0]      req_rdata;
  logic [3:0]       inport_wr;
  logic             inport_rd;
  logic [31:0]      inport_addr, inport_wdata;
  logic             inport_accept, inport_ack, inport_error;
  logic [31:0]      inport_rdata;
  logic [$clog2(D):0] outst_cnt;
  logic             proto_err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  sdram_inport_arbiter #(.NUM_REQ(N), .OUTST_DEPTH(D)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_wr_i(req_wr), .req_rd_i(req_rd), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_accept_o(req_accept), .req_ack_o(req_ack), .req_error_o(req_error), .req_rdata_o(req_rdata),
    .inport_wr_o(inport_wr), .inport_rd_o(inport_rd), .inport_addr_o(inport_addr),
    .inport_wdata_o(inport_wdata), .inport_accept_i(inport_accept), .inport_ack_i(inport_ack),
    .inport_error_i(inport_error), .inport_rdata_i(inport_rdata),
    .outst_cnt_o(outst_cnt), .proto_err_o(proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int r, input logic [3:0] wr, input logic rd,
                         input logic [31:0] addr, input logic [31:0] wd);
    req_wr[4*r +: 4]     = wr;
    req_rd[r]            = rd;
    req_addr[32*r +: 32] = addr;
    req_wdata[32*r +: 32] = wd;
  endtask

  task automatic clr_all();
    req_wr = '0; req_rd = '0; req_addr = '0; req_wdata = '0;
    inport_accept = 1'b0; inport_ack = 1'b0; inport_error = 1'b0; inport_rdata = '0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clr_all();
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  logic [3:0] exp_oh [5];
  logic [31:0] exp_t6_addr;
  int got;

  initial begin
`ifdef SDRAM_ARB_PRIO0_EN
    exp_oh = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    exp_t6_addr = 32'h300;
`else
    exp_oh = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_t6_addr = 32'h303;
`endif
    clr_all();
    #2;
    chk("rst_accept", 32'(req_accept), 0);
    chk("rst_ack", 32'(req_ack), 0);
    chk("rst_inport_rd", 32'(inport_rd), 0);
    chk("rst_cnt", 32'(outst_cnt), 0);
    chk("rst_proto", 32'(proto_err), 0);

    // 1: single write from req0, accept three cycles after grant, then ack
    do_reset();
    set_req(0, 4'hf, 1'b0, 32'h10, 32'hA5A5_5A5A);
    #1 chk("t1_arb_idle", inport_addr, 0);
    cyc();
    chk("t1_addr", inport_addr, 32'h10);
    chk("t1_wr", 32'(inport_wr), 32'hf);
    chk("t1_wdata", inport_wdata, 32'hA5A5_5A5A);
    chk("t1_no_acc0", 32'(req_accept), 0);
    cyc(); chk("t1_no_acc1", 32'(req_accept), 0);
    cyc(); chk("t1_no_acc2", 32'(req_accept), 0);
    cyc(); inport_accept = 1'b1; #1;
    chk("t1_accept", 32'(req_accept), 32'b0001);
    cyc(); set_req(0, 4'h0, 1'b0, 0, 0); inport_accept = 1'b0; #1;
    chk("t1_acc_once", 32'(req_accept), 0);
    chk("t1_cnt1", 32'(outst_cnt), 1);
    cyc(); inport_ack = 1'b1; #1;
    chk("t1_ack", 32'(req_ack), 32'b0001);
    chk("t1_err", 32'(req_error), 0);
    cyc(); inport_ack = 1'b0; #1;
    chk("t1_cnt0", 32'(outst_cnt), 0);

    // 2: all requesters read continuously; grant order from rr_ptr=0
    do_reset();
    for (int r = 0; r < N; r++) set_req(r, 4'h0, 1'b1, 32'h200 + 32'(r), 0);
    inport_accept = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      cyc();
      inport_ack = (outst_cnt != 0);
      #1;
      if (req_ack != 0 && got > 0) chk("t2_ack_route", 32'(req_ack), 32'(exp_oh[got-1]));
      if (req_accept != 0) begin
        chk("t2_order", 32'(req_accept), 32'(exp_oh[got]));
        got++;
      end
    end
    chk("t2_grants", 32'(got), 5);
    inport_ack = 1'b0;

    // 3: fill FIFO with 4 reads, 5th blocked until one ack
    do_reset();
    for (int r = 0; r < N; r++) set_req(r, 4'h0, 1'b1, 32'h400 + 32'(r), 0);
    inport_accept = 1'b1;
    for (int c = 0; c < 8; c++) cyc();
    chk("t3_full", 32'(outst_cnt), 4);
    for (int c = 0; c < 4; c++) begin
      chk("t3_blocked_rd", 32'(inport_rd), 0);
      chk("t3_blocked_acc", 32'(req_accept), 0);
      cyc();
    end
    inport_ack = 1'b1; #1;
    chk("t3_ack_head", 32'(req_ack), 32'b0001);
    cyc(); inport_ack = 1'b0; #1;
    chk("t3_cnt3", 32'(outst_cnt), 3);
    chk("t3_arb_rd", 32'(inport_rd), 0);
    cyc();
    chk("t3_fifth_rd", 32'(inport_rd), 1);
    chk("t3_fifth_acc", 32'(req_accept), 32'b0001);
    cyc();
    chk("t3_cnt4", 32'(outst_cnt), 4);

    // 4: simultaneous accept and ack at count 2
    do_reset();
    set_req(1, 4'h0, 1'b1, 32'h410, 0);
    inport_accept = 1'b1;
    cyc(); chk("t4_acc1", 32'(req_accept), 32'b0010);
    cyc(); set_req(1, 4'h0, 1'b0, 0, 0); set_req(3, 4'h0, 1'b1, 32'h430, 0);
    cyc(); chk("t4_acc3", 32'(req_accept), 32'b1000);
    cyc(); set_req(3, 4'h0, 1'b0, 0, 0); set_req(0, 4'h0, 1'b1, 32'h400, 0); #1;
    chk("t4_cnt2a", 32'(outst_cnt), 2);
    cyc(); inport_ack = 1'b1; #1;
    chk("t4_acc0", 32'(req_accept), 32'b0001);
    chk("t4_ack_old", 32'(req_ack), 32'b0010);
    cyc(); set_req(0, 4'h0, 1'b0, 0, 0); inport_accept = 1'b0; #1;
    chk("t4_cnt2b", 32'(outst_cnt), 2);
    chk("t4_ack3", 32'(req_ack), 32'b1000);
    cyc(); chk("t4_ack_tail", 32'(req_ack), 32'b0001);
    cyc(); inport_ack = 1'b0; #1;
    chk("t4_cnt0", 32'(outst_cnt), 0);

    // 5: error ack routed to req2, then spurious ack
    do_reset();
    set_req(2, 4'h0, 1'b1, 32'h520, 0);
    inport_accept = 1'b1;
    cyc(); chk("t5_acc2", 32'(req_accept), 32'b0100);
    cyc(); set_req(2, 4'h0, 1'b0, 0, 0); inport_accept = 1'b0;
    inport_ack = 1'b1; inport_error = 1'b1; inport_rdata = 32'hDEAD_BEEF; #1;
    chk("t5_ack", 32'(req_ack), 32'b0100);
    chk("t5_err", 32'(req_error), 32'b0100);
    chk("t5_rdata", req_rdata, 32'hDEAD_BEEF);
    cyc(); inport_ack = 1'b0; inport_error = 1'b0; #1;
    chk("t5_cnt0", 32'(outst_cnt), 0);
    chk("t5_proto0", 32'(proto_err), 0);
    inport_ack = 1'b1; #1;
    chk("t5_spur_ack", 32'(req_ack), 0);
    cyc(); inport_ack = 1'b0; #1;
    chk("t5_proto1", 32'(proto_err), 1);
    cyc(); cyc();
    chk("t5_proto_sticky", 32'(proto_err), 1);

    // 6: async reset with 3 outstanding and a grant active
    do_reset();
    for (int r = 0; r < N; r++) set_req(r, 4'h0, 1'b1, 32'h300 + 32'(r), 0);
    inport_accept = 1'b1;
    for (int c = 0; c < 5; c++) cyc();
    cyc(); inport_accept = 1'b0;
    cyc();
    chk("t6_grant_rd", 32'(inport_rd), 1);
    chk("t6_grant_addr", inport_addr, exp_t6_addr);
    chk("t6_cnt3", 32'(outst_cnt), 3);
    #2 rst_ni = 1'b0; inport_accept = 1'b1; inport_ack = 1'b1; inport_rdata = '0;
    #1;
    chk("t6_rd0", 32'(inport_rd), 0);
    chk("t6_addr0", inport_addr, 0);
    chk("t6_acc0", 32'(req_accept), 0);
    chk("t6_ack0", 32'(req_ack), 0);
    chk("t6_cnt0", 32'(outst_cnt), 0);
    chk("t6_rdata0", req_rdata, 0);
    @(posedge clk_i); #1 rst_ni = 1'b1; inport_ack = 1'b0;
    #1 chk("t6_arb_after", 32'(inport_rd), 0);
    cyc();
    chk("t6_first_grant", 32'(req_accept), 32'b0001);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
